// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: states, opcodes, datapath mux codes.
// Also holds the packed control-word struct the FSM decodes each cycle.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_4      = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_eq;
        logic       pc_write_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
        logic       mem_fault;
    } ctl_t;

    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit <-> datapath bundle: opcode and memory handshake in, all enables and status out.
// master = control unit, slave = datapath/memory side.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCondEq;
    logic       PCWriteCondNe;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       illegal_op;
    logic       mem_fault;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCondEq, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, mem_fault, state
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCondEq, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               illegal_op, mem_fault, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for the shared-datapath MIPS: 3-5 cycles per instruction plus memory waits.
// Memory stalls hold FETCH/MEM_READ/MEM_WRITE until mem_ready; a bounded wait aborts to a refetch.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter bit ENABLE_BNE = 1'b1,
    parameter bit ENABLE_IMM = 1'b1,
    parameter int MAX_WAIT   = 15
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_control_if.master bus
);

    localparam int              CNT_W      = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_WAIT);
    localparam bit              TIMEOUT_EN = (MAX_WAIT > 0);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             is_wait;
    logic             timeout;
    ctl_t             ctl;

    assign is_wait = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
    assign timeout = TIMEOUT_EN && is_wait && !bus.mem_ready && (wait_cnt == MAX_CNT);
    // Every non-wait state leaves after one cycle, so only a stalled wait state keeps counting.
    assign cnt_d   = (is_wait && !bus.mem_ready && !timeout) ? wait_cnt + 1'b1 : '0;

    always_comb begin
        ctl     = '0;
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_4;
                ctl.alu_op    = ALUOP_ADD;
                ctl.pc_source = PCSRC_ALU;
                ctl.ir_write  = bus.mem_ready;
                ctl.pc_write  = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctl.alu_src_b = SRCB_IMMSH;
                ctl.alu_op    = ALUOP_ADD;
                if (bus.opcode == OP_RTYPE)
                    state_d = S_R_EXEC;
                else if (bus.opcode == OP_LW || bus.opcode == OP_SW)
                    state_d = S_MEM_ADDR;
                else if (bus.opcode == OP_BEQ || (ENABLE_BNE && bus.opcode == OP_BNE))
                    state_d = S_BRANCH;
                else if (bus.opcode == OP_J)
                    state_d = S_JUMP;
                else if (ENABLE_IMM && is_imm_op(bus.opcode))
                    state_d = S_I_EXEC;
                else begin
                    ctl.illegal_op = 1'b1;
                    state_d        = S_FETCH;
                end
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
                state_d       = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctl.mem_to_reg = 1'b1;
                ctl.reg_write  = 1'b1;
                state_d        = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_R_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_B;
                ctl.alu_op    = ALUOP_FUNCT;
                state_d       = S_R_WB;
            end
            S_R_WB: begin
                ctl.reg_dst   = 1'b1;
                ctl.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a   = 1'b1;
                ctl.alu_src_b   = SRCB_B;
                ctl.alu_op      = ALUOP_SUB;
                ctl.pc_source   = PCSRC_ALUOUT;
                ctl.pc_write_eq = (bus.opcode == OP_BEQ);
                ctl.pc_write_ne = (bus.opcode == OP_BNE);
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                ctl.pc_write  = 1'b1;
                ctl.pc_source = PCSRC_JUMP;
                state_d       = S_FETCH;
            end
            S_I_EXEC: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_IMM;
                state_d       = S_I_WB;
            end
            S_I_WB: begin
                ctl.reg_write = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Abandon the stalled access; PC is untouched so the instruction is refetched.
        if (timeout) begin
            ctl.mem_fault = 1'b1;
            ctl.ir_write  = 1'b0;
            ctl.pc_write  = 1'b0;
            state_d       = S_FETCH;
        end

        if (reset) ctl = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state_q  <= state_d;
            wait_cnt <= cnt_d;
        end
    end

    assign bus.PCWrite       = ctl.pc_write;
    assign bus.PCWriteCondEq = ctl.pc_write_eq;
    assign bus.PCWriteCondNe = ctl.pc_write_ne;
    assign bus.IorD          = ctl.iord;
    assign bus.MemRead       = ctl.mem_read;
    assign bus.MemWrite      = ctl.mem_write;
    assign bus.IRWrite       = ctl.ir_write;
    assign bus.MemtoReg      = ctl.mem_to_reg;
    assign bus.RegDst        = ctl.reg_dst;
    assign bus.RegWrite      = ctl.reg_write;
    assign bus.ALUSrcA       = ctl.alu_src_a;
    assign bus.ALUSrcB       = ctl.alu_src_b;
    assign bus.ALUOp         = ctl.alu_op;
    assign bus.PCSource      = ctl.pc_source;
    assign bus.illegal_op    = ctl.illegal_op;
    assign bus.mem_fault     = ctl.mem_fault;
    assign bus.state         = reset ? 4'd0 : 4'(state_q);

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS control unit: a Moore FSM that sequences each instruction over 3–5 cycles. It drives the PC, IR, memory, ALU-mux and register-file enables of the shared-datapath CPU. It adds `bne`, optional immediate-ALU ops, a memory-ready handshake with a bounded wait counter, and illegal-opcode and memory-fault reporting. It sits beside the datapath, and takes `opcode` from the IR, which holds it stable after fetch.

## Interface
- `ENABLE_BNE`, default 1: when 1, decode opcode 0x05 as `bne`; when 0, 0x05 is illegal.
- `ENABLE_IMM`, default 1: when 1, decode `addi` 0x08, `slti` 0x0A, `andi` 0x0C, `ori` 0x0D; when 0, these are illegal.
- `MAX_WAIT`, default 15: maximum number of wait cycles per memory access; 0 disables the timeout. Counter width is `$clog2(MAX_WAIT+1)` (minimum 1).
- `clk` in 1: the single clock. One clock; reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `opcode` in 6: IR[31:26].
- `mem_ready` in 1: memory has completed the current access this cycle.
- `PCWrite`, `PCWriteCondEq`, `PCWriteCondNe` out 1 each: unconditional and conditional PC load enables.
- `IorD` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `MemRead`, `MemWrite`, `IRWrite` out 1 each.
- `MemtoReg`, `RegDst`, `RegWrite` out 1 each.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp` out 2: 00 = add, 01 = sub, 10 = funct decode, 11 = opcode decode (immediate ops).
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal_op` out 1: one-cycle pulse.
- `mem_fault` out 1: one-cycle pulse.
- `state` out 4: current state, for debug.

## Operation
- Reset behaviour:
  - While `reset` is high, all outputs are 0.
  - On the first cycle after reset, the state is FETCH (0) and the wait counter is 0.
- Encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
- Outputs are decoded from state only, except where qualified by `mem_ready`. Any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only when `mem_ready` is high.
  - Stay in FETCH until `mem_ready`, then go to DECODE.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes the branch target).
  - Next state by opcode: 0x00 → R_EXEC; 0x23 or 0x2B → MEM_ADDR; 0x04 or enabled 0x05 → BRANCH; 0x02 → JUMP; enabled immediate op → I_EXEC.
  - Any other opcode: pulse `illegal_op` and go to FETCH, with no write.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEM_READ if opcode is 0x23, otherwise MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Wait for `mem_ready`, then go to MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1. Go to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1, held until `mem_ready`, then go to FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to R_WB.
- R_WB: RegDst=1, RegWrite=1. Go to FETCH.
- BRANCH:
  - Outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01.
  - PCWriteCondEq=1 if opcode is 0x04; PCWriteCondNe=1 if opcode is 0x05.
  - Go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Go to I_WB.
- I_WB: RegDst=0, MemtoReg=0, RegWrite=1. Go to FETCH.
- Wait counter (wait states are FETCH, MEM_READ, MEM_WRITE):
  - The counter increments on each wait-state cycle without `mem_ready`, and clears on any state change.
  - If MAX_WAIT>0 and the counter equals MAX_WAIT with `mem_ready` still low: pulse `mem_fault`, suppress all commits, and go to FETCH. The PC is unchanged, so the fetch is retried.
- Unknown state encodings (12–15) go to FETCH.

## Timing
- Cycle counts with zero wait: lw 5, sw 4, R-type 4, immediate op 4, beq/bne 3, j 3. Each wait cycle adds one cycle.
- `mem_ready` is sampled in the same cycle that its qualified enables fire. `mem_ready` in any other state is ignored.
- `illegal_op` and `mem_fault` are high for exactly one cycle, in the DECODE or wait-state cycle that causes the FETCH transition.
- Reset mid-instruction: all outputs are forced low that cycle, and the next state is FETCH. No partial write completes after reset.
- Simultaneous `mem_ready` and counter==MAX_WAIT: `mem_ready` wins (normal completion, no fault).

## Structure
- The shared package `mips_ctrl_pkg` holds:
  - the state enum/localparams;
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_BNE`, `OP_J`, `OP_ADDI`, `OP_SLTI`, `OP_ANDI`, `OP_ORI`;
  - the ALUOp, ALUSrcB and PCSource codes.
- Single module. The wait counter is inline; no sub-module is needed.

## Test plan
- R-type: reset, then opcode 0x00 with `mem_ready` tied 1. States 0,1,6,7,0; IRWrite=PCWrite=1 in cycle 0; RegWrite=RegDst=1 in cycle 3.
- lw with 2 wait cycles: `mem_ready` low for 2 cycles in MEM_READ. States 0,1,2,3,3,3,4,0; MemRead=IorD=1 throughout state 3; RegWrite=MemtoReg=1 in state 4.
- Branches:
  - bne with ENABLE_BNE=1: PCWriteCondNe=1 and PCSource=01 in state 8, completing in 3 cycles.
  - Opcode 0x05 with ENABLE_BNE=0: `illegal_op` pulses in DECODE, next state 0, no enables asserted.
- Timeout: MAX_WAIT=3 with `mem_ready` held low in FETCH. `mem_fault` pulses on the 4th FETCH cycle, IRWrite/PCWrite stay 0, and FETCH repeats.
- Reset: assert `reset` in MEM_WRITE. MemWrite drops in the same cycle, and `state`=0 on the next cycle.
- addi with ENABLE_IMM=1: states 0,1,10,11,0; ALUOp=11 and ALUSrcB=10 in state 10; RegWrite=1 and RegDst=0 in state 11.
